morsecode_symbol_tx: RTL and testbench
======================================

// Module: morsecode_symbol_tx
// PURPOSE
//  Downstream of the morse length counter: serializes one encoded letter into on/off keying.
//  Takes up to MAX_LEN dot/dash symbols plus a symbol count and drives led_out with standard
//  ITU timing: dot 1 unit, dash 3 units, intra-letter gap 1 unit, letter gap 3 units.
//  Exposes remaining-symbol count and a done pulse to the letter sequencer.
// PARAMETERS
//  UNIT_CYCLES  25_000_000  clk cycles per morse time unit (>=1; 0.5 s at 50 MHz)
//  MAX_LEN      4           max symbols per letter; pattern_in width
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  reset_n     in   1        asynchronous, active-low reset
//  start       in   1        request to send pattern_in/length_in; accepted only when ready=1
//  pattern_in  in   MAX_LEN  symbol bits, 1=dash 0=dot; bit[length-1] sent first, bit[0] last
//  length_in   in   4        number of symbols to send, 0..15 (values > MAX_LEN clamp to MAX_LEN)
//  ready       out  1        1 in IDLE; start is accepted on an edge where start=1 and ready=1
//  led_out     out  1        keying output, 1 = tone/LED on (registered)
//  sym_left    out  4        symbols not yet fully keyed; loaded at accept, -1 at end of each mark
//  done        out  1        one-cycle pulse: letter including letter gap complete
//  abort       in   1        only when MORSECODE_ABORT_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, ready=1, led_out=0, sym_left=0, done=0, counters=0.
//  States: IDLE, MARK, SPACE, LGAP.
//  IDLE: on accept latch pattern and clamped length into shift/len regs, sym_left<=len.
//    len=0 -> stay IDLE, pulse done next cycle, led_out stays 0.
//    len>0 -> MARK next cycle, led_out=1 from the cycle after accept.
//  Timing: cycle counter counts UNIT_CYCLES per unit; unit counter counts units per state.
//    MARK lasts 1 unit (dot) or 3 units (dash) = exactly UNIT_CYCLES*n cycles, led_out=1.
//    At MARK end: sym_left-=1, shift pattern left; if sym_left becomes 0 -> LGAP else SPACE.
//    SPACE: 1 unit, led_out=0, then MARK.  LGAP: 3 units, led_out=0, then IDLE.
//  Leaving LGAP: ready=1 and done=1 in the same (first IDLE) cycle; done low after one cycle.
//  start while ready=0: ignored, no effect on inputs latched, timing, or outputs.
//  pattern_in/length_in sampled only at accept; changes mid-letter have no effect.
//  Back-to-back: start held high in the done cycle is accepted (ready=1); next mark begins
//    the following cycle (letter gap already completed, no extra gap inserted).
//  sym_left never wraps below 0; counters saturate-free since states bound them.
//  Async reset mid-letter: outputs return to reset values immediately; no done pulse.
//  Letter total cycles = UNIT_CYCLES*(sum marks + (len-1) + 3); latency start->led_out=1 is 1.
// CONFIGURATION
//  MORSECODE_ABORT_EN defined: abort port exists; abort=1 in any non-IDLE state forces IDLE
//    on the next edge: led_out=0, sym_left=0, ready=1, done NOT pulsed; abort has priority
//    over start in the same cycle; abort in IDLE ignored.
//  Not defined: abort port absent; a letter always runs to completion.
// TESTING (UNIT_CYCLES=2, MAX_LEN=4; accept edge = cycle 0)
//  'A': pattern=4'b0001 len=2 -> led_out 1 @c1-2, 0 @c3-4, 1 @c5-10, 0 @c11-16; done=1,ready=1 @c17;
//    sym_left 2->1 after c2, 1->0 after c10.
//  'S': pattern=0000 len=3 -> three 2-cycle marks separated by 2-cycle spaces, 6-cycle gap; done @c17.
//  len=0 -> led_out stays 0, done pulse @c1, ready never drops; len=9 pattern=1111 -> 4 dashes only.
//  start pulsed at c4 of a letter with different pattern -> ignored, waveform identical to case 1.
//  reset_n low at c6 of 'A' -> led_out,sym_left,done =0 and ready=1 immediately; no done afterwards.
//  MORSECODE_ABORT_EN: abort=1 at c5 of 'A' -> c6 IDLE, led_out=0, sym_left=0, no done pulse.

Source files
------------

// File: rtl/morsecode_symbol_tx_if.sv
// ---------------------------------------------------------------------------
// morsecode_symbol_tx_if
//   Letter handshake between the letter sequencer (master) and the morse
//   symbol transmitter (slave).
//
//   Signals
//     start       master->slave  request to send pattern_in/length_in
//     pattern_in  master->slave  MAX_LEN symbol bits, 1=dash 0=dot,
//                                bit[length-1] keyed first
//     length_in   master->slave  symbol count 0..15 (clamped to MAX_LEN)
//     ready       slave->master  transmitter idle, start will be accepted
//     led_out     slave->master  keying output, 1 = tone/LED on
//     sym_left    slave->master  symbols not yet fully keyed
//     done        slave->master  one-cycle pulse, letter + letter gap done
// ---------------------------------------------------------------------------
interface morsecode_symbol_tx_if #(
  parameter int MAX_LEN = 4
);
  logic               start;
  logic [MAX_LEN-1:0] pattern_in;
  logic [3:0]         length_in;
  logic               ready;
  logic               led_out;
  logic [3:0]         sym_left;
  logic               done;

  modport master (
    output start,
    output pattern_in,
    output length_in,
    input  ready,
    input  led_out,
    input  sym_left,
    input  done
  );

  modport slave (
    input  start,
    input  pattern_in,
    input  length_in,
    output ready,
    output led_out,
    output sym_left,
    output done
  );
endinterface

// File: rtl/morsecode_symbol_tx.sv
// ---------------------------------------------------------------------------
// morsecode_symbol_tx
//   Serializes one encoded morse letter into on/off keying with ITU timing:
//   dot = 1 unit, dash = 3 units, gap between symbols = 1 unit, gap after
//   the letter = 3 units. One unit is UNIT_CYCLES clock cycles.
//
//   Parameters
//     UNIT_CYCLES  clk cycles per morse time unit (>= 1)
//     MAX_LEN      maximum symbols per letter (<= 15), pattern width
//
//   Ports
//     clk      in   system clock, all logic on posedge
//     reset_n  in   asynchronous active-low reset
//     abort    in   only with MORSECODE_ABORT_EN: cancel the current letter
//     bus      slave modport of morsecode_symbol_tx_if (start/pattern_in/
//              length_in in; ready/led_out/sym_left/done out)
//
//   Build option
//     MORSECODE_ABORT_EN  when defined, adds the abort port. abort=1 in any
//                         non-IDLE state returns to IDLE on the next edge
//                         without a done pulse; it wins over start. abort in
//                         IDLE is ignored. When undefined, a letter always
//                         runs to completion.
// ---------------------------------------------------------------------------
module morsecode_symbol_tx #(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int MAX_LEN     = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
`ifdef MORSECODE_ABORT_EN
  input  logic                        abort,
`endif
  morsecode_symbol_tx_if.slave        bus
);

  // State encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;
  localparam logic [1:0] ST_LGAP  = 2'd3;

  // Cycle counter sized for UNIT_CYCLES; a 1-cycle unit still needs 1 bit.
  localparam int            CW        = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(UNIT_CYCLES - 1);
  localparam logic [3:0]    MAX_LEN_4 = 4'(MAX_LEN);

  // Registers
  logic [1:0]         state_reg,    state_next;
  logic [MAX_LEN-1:0] shift_reg,    shift_next;
  logic [3:0]         sym_left_reg, sym_left_next;
  logic [CW-1:0]      cycle_cnt_reg, cycle_cnt_next;
  logic [1:0]         unit_cnt_reg, unit_cnt_next;
  logic               led_reg,      led_next;
  logic               done_reg,     done_next;

  // Helpers
  logic [3:0]         len_clamped;
  logic [MAX_LEN-1:0] pattern_aligned;
  logic [1:0]         unit_last;
  logic               unit_end;
  logic               state_end;
  logic               abort_req;

`ifdef MORSECODE_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Length clamp and MSB-alignment of the pattern: the first symbol to key
  // is bit[len-1], so shift it up to bit[MAX_LEN-1] where MARK reads it.
  always_comb begin
    len_clamped     = (bus.length_in > MAX_LEN_4) ? MAX_LEN_4 : bus.length_in;
    pattern_aligned = bus.pattern_in << (MAX_LEN_4 - len_clamped);
  end

  // Index of the final unit in the current state (units counted from 0).
  always_comb begin
    case (state_reg)
      ST_MARK: unit_last = shift_reg[MAX_LEN-1] ? 2'd2 : 2'd0;
      ST_LGAP: unit_last = 2'd2;
      default: unit_last = 2'd0;
    endcase
  end

  assign unit_end  = (cycle_cnt_reg == CYC_LAST);
  assign state_end = unit_end && (unit_cnt_reg == unit_last);

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    sym_left_next  = sym_left_reg;
    cycle_cnt_next = cycle_cnt_reg;
    unit_cnt_next  = unit_cnt_reg;
    led_next       = led_reg;
    done_next      = 1'b0;

    // Timing runs in every keying state; each state change below resets it.
    if (state_reg != ST_IDLE) begin
      if (unit_end) begin
        cycle_cnt_next = '0;
        unit_cnt_next  = unit_cnt_reg + 2'd1;
      end else begin
        cycle_cnt_next = cycle_cnt_reg + CW'(1);
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          sym_left_next  = len_clamped;
          shift_next     = pattern_aligned;
          cycle_cnt_next = '0;
          unit_cnt_next  = '0;
          if (len_clamped == 4'd0) begin
            // Empty letter: nothing to key, just acknowledge.
            done_next = 1'b1;
          end else begin
            state_next = ST_MARK;
            led_next   = 1'b1;
          end
        end
      end

      ST_MARK: begin
        if (state_end) begin
          cycle_cnt_next = '0;
          unit_cnt_next  = '0;
          led_next       = 1'b0;
          shift_next     = shift_reg << 1;
          if (sym_left_reg != 4'd0) begin
            sym_left_next = sym_left_reg - 4'd1;
          end
          // Last symbol just finished -> letter gap instead of symbol gap.
          state_next = (sym_left_reg <= 4'd1) ? ST_LGAP : ST_SPACE;
        end
      end

      ST_SPACE: begin
        if (state_end) begin
          cycle_cnt_next = '0;
          unit_cnt_next  = '0;
          led_next       = 1'b1;
          state_next     = ST_MARK;
        end
      end

      ST_LGAP: begin
        if (state_end) begin
          cycle_cnt_next = '0;
          unit_cnt_next  = '0;
          done_next      = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Cancel overrides everything, including a start in the same cycle.
    if (abort_req && (state_reg != ST_IDLE)) begin
      state_next     = ST_IDLE;
      sym_left_next  = '0;
      shift_next     = '0;
      cycle_cnt_next = '0;
      unit_cnt_next  = '0;
      led_next       = 1'b0;
      done_next      = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      sym_left_reg  <= '0;
      cycle_cnt_reg <= '0;
      unit_cnt_reg  <= '0;
      led_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      sym_left_reg  <= sym_left_next;
      cycle_cnt_reg <= cycle_cnt_next;
      unit_cnt_reg  <= unit_cnt_next;
      led_reg       <= led_next;
      done_reg      <= done_next;
    end
  end

  // Outputs
  assign bus.ready    = (state_reg == ST_IDLE);
  assign bus.led_out  = led_reg;
  assign bus.sym_left = sym_left_reg;
  assign bus.done     = done_reg;

endmodule

// File: tb/tb_morsecode_symbol_tx.sv
module tb_morsecode_symbol_tx;
  localparam int U = 2;
  localparam int MAX_LEN = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
`ifdef MORSECODE_ABORT_EN
  logic abort = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Expected {ready, done, led_out, sym_left} per cycle after accept.
  logic [6:0] exp_q[$];

  morsecode_symbol_tx_if #(.MAX_LEN(MAX_LEN)) bus ();

  morsecode_symbol_tx #(
    .UNIT_CYCLES(U),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
`ifdef MORSECODE_ABORT_EN
    .abort  (abort),
`endif
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] observe();
    return {bus.ready, bus.done, bus.led_out, bus.sym_left};
  endfunction

  task automatic check(input string tag, input logic [6:0] expected);
    logic [6:0] obs;
    obs = observe();
    vectors++;
    assert (obs === expected) else begin
      miscompares++;
      $error("FAIL %s observed rdy/done/led/sym=%b expected=%b", tag, obs, expected);
    end
  endtask

  // Builds the expected waveform of one letter from the ITU timing rules.
  task automatic push_letter(input logic [3:0] pat, input logic [3:0] len);
    int l;
    int sym;
    int n;
    l = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
    if (l == 0) begin
      exp_q.push_back({1'b1, 1'b1, 1'b0, 4'd0});
      return;
    end
    sym = l;
    for (int i = l - 1; i >= 0; i--) begin
      n = pat[i] ? 3 * U : U;
      repeat (n) exp_q.push_back({1'b0, 1'b0, 1'b1, 4'(sym)});
      sym--;
      if (sym > 0) repeat (U) exp_q.push_back({1'b0, 1'b0, 1'b0, 4'(sym)});
      else repeat (3 * U) exp_q.push_back({1'b0, 1'b0, 1'b0, 4'd0});
    end
    exp_q.push_back({1'b1, 1'b1, 1'b0, 4'd0});
  endtask

  // Called at a negedge while ready=1; accept happens on the next posedge.
  task automatic begin_letter(input logic [3:0] pat, input logic [3:0] len);
    bus.start      = 1'b1;
    bus.pattern_in = pat;
    bus.length_in  = len;
    push_letter(pat, len);
    $display("letter start pattern=%b len=%0d expected cycles=%0d", pat, len, exp_q.size());
  endtask

  // Pops and compares one expected entry per cycle; optional ignored start
  // with a different pattern at cycle poke_at.
  task automatic run_letter(input string tag, input int poke_at, input int max_n);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < max_n) begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      if (k == poke_at) begin
        bus.start      = 1'b1;
        bus.pattern_in = 4'b1111;
        bus.length_in  = 4'd4;
      end
      check($sformatf("%s_c%0d", tag, k), exp_q.pop_front());
    end
    bus.start = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("%s_%0d", tag, i), {1'b1, 1'b0, 1'b0, 4'd0});
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.pattern_in = '0;
    bus.length_in  = '0;

    #1;
    check("reset_state", {1'b1, 1'b0, 1'b0, 4'd0});
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("idle", 3);

    // 'A' then 'S' back to back (start during the done cycle).
    begin_letter(4'b0001, 4'd2);
    run_letter("A", 0, 100);
    begin_letter(4'b0000, 4'd3);
    run_letter("S", 0, 100);
    idle_check("post_S", 2);

    // Empty letter: immediate done, ready never drops.
    begin_letter(4'b1010, 4'd0);
    run_letter("len0", 0, 100);
    idle_check("post_len0", 2);

    // Oversized length clamps to 4 dashes.
    begin_letter(4'b1111, 4'd9);
    run_letter("len9", 0, 100);
    idle_check("post_len9", 1);

    // Start with a different pattern while busy is ignored.
    begin_letter(4'b0001, 4'd2);
    run_letter("A_poke", 4, 100);
    idle_check("post_poke", 1);

    // Mixed patterns back to back: 'Q' then 'K'.
    begin_letter(4'b1101, 4'd4);
    run_letter("Q", 0, 100);
    begin_letter(4'b0101, 4'd3);
    run_letter("K", 0, 100);
    idle_check("post_K", 1);

    // Async reset at c6 of 'A'.
    begin_letter(4'b0001, 4'd2);
    run_letter("A_rst", 0, 6);
    exp_q.delete();
    #1 reset_n = 1'b0;
    #1 check("reset_async", {1'b1, 1'b0, 1'b0, 4'd0});
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("post_reset", 20);

`ifdef MORSECODE_ABORT_EN
    // Abort at c5 of 'A'.
    begin_letter(4'b0001, 4'd2);
    run_letter("A_abort", 0, 5);
    exp_q.delete();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_c6", {1'b1, 1'b0, 1'b0, 4'd0});
    idle_check("post_abort", 20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
